// File: rtl/pc_ras_pkg.sv
// Shared configuration for the program counter / return-address stack.
// It holds the default widths and vectors, plus the single-cycle action priority.
package pc_ras_pkg;

    localparam int DEF_RW      = 16;
    localparam int DEF_INT_VEC = 1;
    localparam int DEF_UFL_VEC = 0;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_INC,
        ACT_IE,
        ACT_CALL,
        ACT_RET,
        ACT_IRQ
    } act_e;

    // Only one PC action runs per cycle: irq > ret > call > ie > inc.
    function automatic act_e decode_action(
        input logic irq,
        input logic ret,
        input logic call,
        input logic ie,
        input logic inc
    );
        if (irq)       return ACT_IRQ;
        else if (ret)  return ACT_RET;
        else if (call) return ACT_CALL;
        else if (ie)   return ACT_IE;
        else if (inc)  return ACT_INC;
        else           return ACT_HOLD;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address buffer. When the buffer is full, a push overwrites the oldest entry.
// A pop on an empty stack leaves it untouched. Both cases are flagged so the owner can record an error.
module ras_stack
    import pc_ras_pkg::*;
#(
    parameter  int W     = DEF_RW,
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clr,
    input  logic [W-1:0]  push_data,
    output logic [W-1:0]  top,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          empty,
    output logic          push_ovf,
    output logic          pop_ufl
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign push_ovf = push & full;
    assign pop_ufl  = pop & empty;
    assign top      = mem[ptr - PW'(1)];

    // push and pop are never raised together by the owner. The pointer keeps
    // moving under clr, because only the count is discarded.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr <= '0;
            cnt <= '0;
        end else begin
            if (push)
                ptr <= ptr + PW'(1);
            else if (pop && !empty)
                ptr <= ptr - PW'(1);

            if (clr)
                cnt <= '0;
            else if (push && !full)
                cnt <= cnt + CW'(1);
            else if (pop && !empty)
                cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[ptr] <= push_data;
    end

endmodule

// File: rtl/pc_ras.sv
// Fetch program counter with hardware call/return/interrupt-entry support.
// It also drives the page-overflow strobe for the address-extension logic.
module pc_ras
    import pc_ras_pkg::*;
#(
    parameter  int RW      = DEF_RW,
    parameter  int DEPTH   = 8,
    parameter  int OVF_BIT = 14,
    parameter  int INT_VEC = DEF_INT_VEC,
    parameter  int UFL_VEC = DEF_UFL_VEC,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic [RW-1:0] o_pc,
    input  logic [RW-1:0] i_bus,
    input  logic          i_c_pc_inc,
    input  logic          i_c_pc_ie,
    input  logic          i_c_pc_irq,
    input  logic          i_c_pc_call,
    input  logic          i_c_pc_ret,
    input  logic          i_c_ras_clr,
    output logic          o_pc_ovf,
    output logic [RW-1:0] o_ras_top,
    output logic [CW-1:0] o_ras_cnt,
    output logic          o_ras_full,
    output logic          o_ras_empty,
    output logic          o_ras_err
);

    act_e          act;
    logic          stk_push;
    logic          stk_pop;
    logic [RW-1:0] stk_data;
    logic          stk_ovf;
    logic          stk_ufl;
    logic [RW-1:0] pc_next;

    // An interrupt saves the address of the instruction it pre-empted.
    // A call saves the address of the instruction that follows the call.
    always_comb begin
        act      = decode_action(i_c_pc_irq, i_c_pc_ret, i_c_pc_call, i_c_pc_ie, i_c_pc_inc);
        stk_push = (act == ACT_IRQ) || (act == ACT_CALL);
        stk_pop  = (act == ACT_RET);
        stk_data = (act == ACT_IRQ) ? o_pc : o_pc + RW'(1);
    end

    ras_stack #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_stack (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (stk_push),
        .pop       (stk_pop),
        .clr       (i_c_ras_clr),
        .push_data (stk_data),
        .top       (o_ras_top),
        .cnt       (o_ras_cnt),
        .full      (o_ras_full),
        .empty     (o_ras_empty),
        .push_ovf  (stk_ovf),
        .pop_ufl   (stk_ufl)
    );

    always_comb begin
        pc_next = o_pc;
        unique case (act)
            ACT_IRQ:  pc_next = RW'(INT_VEC);
            ACT_RET:  pc_next = o_ras_empty ? RW'(UFL_VEC) : o_ras_top;
            ACT_CALL: pc_next = i_bus;
            ACT_IE:   pc_next = i_bus;
            ACT_INC:  pc_next = o_pc + RW'(1);
            default:  pc_next = o_pc;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_pc <= '0;
        else
            o_pc <= pc_next;
    end

    // A clear wins over a stack error raised in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_ras_err <= 1'b0;
        else if (i_c_ras_clr)
            o_ras_err <= 1'b0;
        else if (stk_ovf || stk_ufl)
            o_ras_err <= 1'b1;
    end

    assign o_pc_ovf = o_pc[OVF_BIT] & (act == ACT_INC);

endmodule

// File: tb/tb_pc_ras.sv
// Testbench for pc_ras. Directed steps and random steps are compared against a queue-based model.
// The model is built from the call/return/interrupt rules.
module tb_pc_ras;

    localparam int RW      = 16;
    localparam int DEPTH   = 8;
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int OVF_BIT = 14;
    localparam logic [RW-1:0] INT_VEC = 16'h0001;
    localparam logic [RW-1:0] UFL_VEC = 16'h0000;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [RW-1:0] o_pc;
    logic [RW-1:0] i_bus;
    logic          i_c_pc_inc, i_c_pc_ie, i_c_pc_irq, i_c_pc_call, i_c_pc_ret, i_c_ras_clr;
    logic          o_pc_ovf;
    logic [RW-1:0] o_ras_top;
    logic [CW-1:0] o_ras_cnt;
    logic          o_ras_full, o_ras_empty, o_ras_err;

    always #5 i_clk = ~i_clk;

    pc_ras #(
        .RW      (RW),
        .DEPTH   (DEPTH),
        .OVF_BIT (OVF_BIT),
        .INT_VEC (1),
        .UFL_VEC (0)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .o_pc        (o_pc),
        .i_bus       (i_bus),
        .i_c_pc_inc  (i_c_pc_inc),
        .i_c_pc_ie   (i_c_pc_ie),
        .i_c_pc_irq  (i_c_pc_irq),
        .i_c_pc_call (i_c_pc_call),
        .i_c_pc_ret  (i_c_pc_ret),
        .i_c_ras_clr (i_c_ras_clr),
        .o_pc_ovf    (o_pc_ovf),
        .o_ras_top   (o_ras_top),
        .o_ras_cnt   (o_ras_cnt),
        .o_ras_full  (o_ras_full),
        .o_ras_empty (o_ras_empty),
        .o_ras_err   (o_ras_err)
    );

    int testCount = 0;
    int failCount = 0;

    logic [RW-1:0] mPc;
    logic          mErr;
    logic [RW-1:0] mStack[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".pc"}, 32'(o_pc), 32'(mPc));
        check({tag, ".cnt"}, 32'(o_ras_cnt), 32'(mStack.size()));
        check({tag, ".empty"}, 32'(o_ras_empty), 32'(mStack.size() == 0));
        check({tag, ".full"}, 32'(o_ras_full), 32'(mStack.size() == DEPTH));
        check({tag, ".err"}, 32'(o_ras_err), 32'(mErr));
        if (mStack.size() > 0)
            check({tag, ".top"}, 32'(o_ras_top), 32'(mStack[$]));
    endtask

    task automatic modelReset();
        mPc  = '0;
        mErr = 1'b0;
        mStack.delete();
    endtask

    task automatic modelPush(input logic [RW-1:0] val, input logic clr);
        if (mStack.size() == DEPTH) begin
            void'(mStack.pop_front());
            if (!clr) mErr = 1'b1;
        end
        mStack.push_back(val);
    endtask

    task automatic modelStep(input logic [RW-1:0] bus, input logic inc, input logic ie,
                             input logic call, input logic ret, input logic irq, input logic clr);
        if (irq) begin
            modelPush(mPc, clr);
            mPc = INT_VEC;
        end else if (ret) begin
            if (mStack.size() == 0) begin
                mPc = UFL_VEC;
                if (!clr) mErr = 1'b1;
            end else begin
                mPc = mStack.pop_back();
            end
        end else if (call) begin
            modelPush(mPc + 16'd1, clr);
            mPc = bus;
        end else if (ie) begin
            mPc = bus;
        end else if (inc) begin
            mPc = mPc + 16'd1;
        end
        if (clr) begin
            mStack.delete();
            mErr = 1'b0;
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [RW-1:0] bus, input logic inc,
                                 input logic ie, input logic call, input logic ret,
                                 input logic irq, input logic clr);
        logic expOvf;
        @(negedge i_clk);
        i_bus       = bus;
        i_c_pc_inc  = inc;
        i_c_pc_ie   = ie;
        i_c_pc_call = call;
        i_c_pc_ret  = ret;
        i_c_pc_irq  = irq;
        i_c_ras_clr = clr;
        #1;
        expOvf = mPc[OVF_BIT] & inc & ~ie & ~call & ~ret & ~irq;
        check({tag, ".ovf"}, 32'(o_pc_ovf), 32'(expOvf));
        @(posedge i_clk);
        modelStep(bus, inc, ie, call, ret, irq, clr);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        i_rst = 1'b1;
        i_bus = '0;
        {i_c_pc_inc, i_c_pc_ie, i_c_pc_irq, i_c_pc_call, i_c_pc_ret, i_c_ras_clr} = '0;
        modelReset();
        #1;
        checkOutput("reset");
        @(negedge i_clk);
        i_rst = 1'b0;

        // Plain increment from reset
        for (int i = 0; i < 3; i++)
            applyStimulus("inc", 16'hFFFF, 1, 0, 0, 0, 0, 0);
        check("inc3_pc", 32'(o_pc), 32'h3);

        // Page overflow strobe, then suppression by a concurrent jump
        applyStimulus("ie4000", 16'h4000, 0, 1, 0, 0, 0, 0);
        applyStimulus("ovf_inc", 16'h0000, 1, 0, 0, 0, 0, 0);
        check("ovf_pc", 32'(o_pc), 32'h4001);
        applyStimulus("ovf_ie", 16'h1234, 1, 1, 0, 0, 0, 0);

        // Call and return
        applyStimulus("ie0010", 16'h0010, 0, 1, 0, 0, 0, 0);
        applyStimulus("call", 16'h0200, 0, 0, 1, 0, 0, 0);
        check("call_top", 32'(o_ras_top), 32'h0011);
        applyStimulus("ret", 16'h0000, 0, 0, 0, 1, 0, 0);
        check("ret_pc", 32'(o_pc), 32'h0011);

        // Interrupt beats call/ie/inc
        applyStimulus("ie0123", 16'h0123, 0, 1, 0, 0, 0, 0);
        applyStimulus("irq", 16'h5555, 1, 1, 1, 0, 1, 0);
        check("irq_pc", 32'(o_pc), 32'h0001);
        check("irq_top", 32'(o_ras_top), 32'h0123);
        applyStimulus("irq_ret", 16'h0000, 0, 0, 0, 1, 0, 0);

        // Overfill the stack, drain it, underflow, then clear
        for (int i = 0; i < 9; i++) begin
            applyStimulus("fill_ie", 16'(i), 0, 1, 0, 0, 0, 0);
            applyStimulus("fill_call", 16'(16'h0300 + i), 0, 0, 1, 0, 0, 0);
        end
        check("fill_err", 32'(o_ras_err), 32'h1);
        for (int i = 0; i < 8; i++)
            applyStimulus("drain_ret", 16'h0000, 0, 0, 0, 1, 0, 0);
        check("drain_last_pc", 32'(o_pc), 32'h2);
        applyStimulus("ufl_ret", 16'h0000, 0, 0, 0, 1, 0, 0);
        check("ufl_pc", 32'(o_pc), 32'(UFL_VEC));
        applyStimulus("clr", 16'h0000, 0, 0, 0, 0, 0, 1);

        // Clear together with a return on a non-empty stack
        applyStimulus("pre_call", 16'h0A00, 0, 0, 1, 0, 0, 0);
        applyStimulus("clr_ret", 16'h0000, 0, 0, 0, 1, 0, 1);

        // Asynchronous reset between edges, mid call sequence
        for (int i = 0; i < 3; i++)
            applyStimulus("pre_rst_call", 16'(16'h0700 + i), 0, 0, 1, 0, 0, 0);
        @(negedge i_clk);
        {i_c_pc_inc, i_c_pc_ie, i_c_pc_irq, i_c_pc_call, i_c_pc_ret, i_c_ras_clr} = '0;
        #2;
        i_rst = 1'b1;
        #1;
        modelReset();
        checkOutput("async_rst");
        #1;
        i_rst = 1'b0;
        applyStimulus("rst_ret", 16'h0000, 0, 0, 0, 1, 0, 0);

        // Random mix of all controls
        for (int n = 0; n < 400; n++) begin
            applyStimulus("rand", 16'($urandom),
                          ($urandom_range(99) < 50), ($urandom_range(99) < 15),
                          ($urandom_range(99) < 20), ($urandom_range(99) < 20),
                          ($urandom_range(99) < 5),  ($urandom_range(99) < 3));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/pc_ras.md
Name: pc_ras

Overview:
- Parametrised program counter with an integrated return-address stack (RAS), successor to the single-register core PC.
- Adds hardware call/return and interrupt-entry push, configurable width, page-overflow bit and vectors.
- Sits in the core fetch path: drives the fetch address; is loaded from the internal data bus by the control unit; reports page overflow to the address-extension logic.

Parameters:
- RW, 16, PC and bus width in bits.
- DEPTH, 8, number of RAS entries (power of two, >=2).
- OVF_BIT, 14, PC bit whose set state, combined with an effective increment, flags page overflow.
- INT_VEC, 1, PC value loaded on interrupt entry.
- UFL_VEC, 0, PC value loaded on return from an empty stack.

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  asynchronous reset, active-high
- o_pc  out  RW  current program counter (registered)
- i_bus  in  RW  jump/call target from internal bus
- i_c_pc_inc  in  1  increment PC
- i_c_pc_ie  in  1  load PC from i_bus (jump)
- i_c_pc_irq  in  1  interrupt entry
- i_c_pc_call  in  1  call: push return address, load i_bus
- i_c_pc_ret  in  1  return: pop top into PC
- i_c_ras_clr  in  1  clear stack and error flag
- o_pc_ovf  out  1  page-overflow strobe (combinational)
- o_ras_top  out  RW  current top-of-stack value (undefined-but-stable when empty)
- o_ras_cnt  out  $clog2(DEPTH+1)  valid entry count
- o_ras_full  out  1  cnt == DEPTH
- o_ras_empty  out  1  cnt == 0
- o_ras_err  out  1  sticky: push overflow or pop underflow occurred

Behaviour:
- Reset (async, immediate): o_pc=0, cnt=0, top pointer=0, err=0. Stack storage is not reset.
- One PC action per cycle, priority irq > ret > call > ie > inc. No control asserted: hold.
- irq: push o_pc (address of the interrupted, unexecuted instruction); o_pc<=INT_VEC.
- ret: o_pc<=o_ras_top; cnt-1. If empty: o_pc<=UFL_VEC, cnt stays 0, err<=1.
- call: push o_pc+1 (mod 2^RW); o_pc<=i_bus.
- ie: o_pc<=i_bus. inc: o_pc<=o_pc+1, wraps mod 2^RW.
- Push when full: circular overwrite of the oldest entry, cnt stays DEPTH, err<=1. The new value becomes top; the following DEPTH pops return the newest DEPTH values.
- Storage is a circular buffer with a top pointer mod DEPTH. o_ras_top is a combinational read of buffer[ptr-1]. Push/pop take effect at the clock edge; values are visible the next cycle.
- i_c_ras_clr: cnt<=0, err<=0, and any push/pop count change in the same cycle is discarded. The PC action still executes; a simultaneous ret loads the pre-clear top (or UFL_VEC if already empty, with err kept 0).
- o_pc_ovf = o_pc[OVF_BIT] & i_c_pc_inc & ~irq & ~ret & ~call & ~ie. It is asserted only when increment is the effective action.
- Flags o_ras_full/empty derive from the registered cnt; there is no bypass.
- Reset asserted mid-sequence: all state is cleared asynchronously. The first edge after deassertion behaves as from a fresh reset.

Decomposition:
- Shared core package/config holds RW, default INT_VEC/UFL_VEC, and the action-priority encoding (localparam enum ACT_HOLD, ACT_INC, ACT_IE, ACT_CALL, ACT_RET, ACT_IRQ).
- One sub-module: ras_stack (circular buffer, pointer, count, full/empty, overflow/underflow indications). It has push/pop/clr inputs and a push data input.
- pc_ras holds the PC register, the priority decode, the ovf strobe and the sticky err.

Test Plan:
- Reset then 3 cycles inc -> o_pc 0,1,2,3; o_pc_ovf=0; o_ras_empty=1.
- o_pc=0x4000 (via ie), inc -> o_pc_ovf=1 that cycle, o_pc=0x4001. Same cycle with ie also high -> o_pc_ovf=0, o_pc=i_bus.
- o_pc=0x0010, call i_bus=0x0200 -> o_pc=0x0200, top=0x0011, cnt=1. Then ret -> o_pc=0x0011, cnt=0.
- irq at o_pc=0x0123 together with call/ie/inc -> o_pc=0x0001, top=0x0123. Then ret -> o_pc=0x0123.
- DEPTH=8: 9 calls from PCs 0..8 (each preceded by ie). Expect cnt=8, err=1. Then 8 rets yield 9,8,...,2. A 9th ret yields o_pc=0, err stays 1. i_c_ras_clr -> err=0, cnt=0.
- Assert i_rst asynchronously mid-call sequence (cnt=3) between edges -> o_pc, cnt, err all 0 immediately. A ret after deassertion -> o_pc=UFL_VEC, err=1.
